// File: rtl/keypad_pkg.sv
// Shared keypad constants and code helpers, also used by the game graphics stage.
// A key code is {valid, row[1:0], col[1:0]}.
package keypad_pkg;

  localparam int KEY_W         = 5;
  localparam int KEY_VALID_BIT = 4;

  typedef logic [KEY_W-1:0] key_code_t;

  localparam key_code_t KEY_NONE = 5'h00;
  localparam key_code_t KEY_1    = 5'h11;
  localparam key_code_t KEY_3    = 5'h13;
  localparam key_code_t KEY_5    = 5'h15;

  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    if (rows[0]) begin
      return 2'd0;
    end else if (rows[1]) begin
      return 2'd1;
    end else if (rows[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic key_code_t make_code(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    code                = {1'b0, row, col};
    code[KEY_VALID_BIT] = 1'b1;
    return code;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad matrix wiring plus the debounced key outputs.
// master = keypad front end, slave = matrix / downstream consumer.
interface keypad_if;
  import keypad_pkg::*;

  logic [3:0] key_row;
  logic [3:0] key_col;
  key_code_t  key;
  key_code_t  key_pulse;

  modport master (input key_row, output key_col, output key, output key_pulse);
  modport slave  (output key_row, input key_col, input key, input key_pulse);

endinterface

// File: rtl/keypad_debounce.sv
// Whole-scan debouncer: a code must repeat for DEBOUNCE_SCANS consecutive
// end-of-scan results before it is accepted onto key.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      scan_end,
  input  key_code_t raw,
  output key_code_t key,
  output key_code_t key_pulse
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);

  key_code_t  cand;
  logic [3:0] cnt;
  logic       accept;

  assign accept = (cnt == CNT_MAX) && (cand != key);

  // candidate code and its saturating run length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= KEY_NONE;
      cnt  <= 4'd0;
    end else if (scan_end) begin
      if (raw == cand) begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 4'd1;
        end else begin
          cnt <= cnt;
        end
      end else begin
        cand <= raw;
        cnt  <= 4'd1;
      end
    end else begin
      cnt <= cnt;
    end
  end

  // releases update key silently; only new pressed codes pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key       <= KEY_NONE;
      key_pulse <= KEY_NONE;
    end else if (accept) begin
      key       <= cand;
      key_pulse <= cand[KEY_VALID_BIT] ? cand : KEY_NONE;
    end else begin
      key_pulse <= KEY_NONE;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad front end: one-hot column drive, 2-flop row synchroniser,
// per-scan first-key accumulator feeding the whole-scan debouncer.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col;
  logic [3:0]       col_drive;
  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  key_code_t        acc;
  key_code_t        acc_next;
  logic             sample;
  logic             scan_end;

  // rows are sampled on the last divider count so the synchroniser has settled
  assign sample   = (div_cnt == DIV_LAST);
  assign scan_end = sample && (col == 2'd3);

  // column divider and one-hot drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      col       <= 2'd0;
      col_drive <= 4'b0001;
    end else if (sample) begin
      div_cnt   <= '0;
      col       <= col + 2'd1;
      col_drive <= {col_drive[2:0], col_drive[3]};
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // two-flop synchroniser on the asynchronous row inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'b0000;
      row_sync <= 4'b0000;
    end else begin
      row_meta <= kp.key_row;
      row_sync <= row_meta;
    end
  end

  // first key found in a scan wins: lowest column, then lowest row
  always_comb begin
    acc_next = acc;
    if ((acc == KEY_NONE) && (|row_sync)) begin
      acc_next = make_code(lowest_row(row_sync), col);
    end else begin
      acc_next = acc;
    end
  end

  // accumulator restarts empty for column 0 of every scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= KEY_NONE;
    end else if (scan_end) begin
      acc <= KEY_NONE;
    end else if (sample) begin
      acc <= acc_next;
    end else begin
      acc <= acc;
    end
  end

  assign kp.key_col = col_drive;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .scan_end (scan_end),
    .raw      (acc_next),
    .key      (kp.key),
    .key_pulse(kp.key_pulse)
  );

endmodule
